// File: rtl/sram_arbiter.sv
// Two-port arbiter for the shared off-chip SRAM: video reads (priority) and game read/write.
// Sequences the address/strobe phases, write turnaround and the starvation guard for the game port.
module sram_arbiter #(
  parameter int ADDR_W     = 20,
  parameter int DATA_W     = 16,
  parameter int ACCESS_CYC = 2,
  parameter int STARVE_MAX = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_vid_req,
  input  logic [ADDR_W-1:0] i_vid_addr,
  output logic              o_vid_gnt,
  output logic [DATA_W-1:0] o_vid_rdata,
  output logic              o_vid_rvalid,
  input  logic              i_gm_req,
  input  logic              i_gm_we,
  input  logic [ADDR_W-1:0] i_gm_addr,
  input  logic [DATA_W-1:0] i_gm_wdata,
  input  logic [1:0]        i_gm_be,
  output logic              o_gm_gnt,
  output logic [DATA_W-1:0] o_gm_rdata,
  output logic              o_gm_rvalid,
  output logic [ADDR_W-1:0] o_sram_addr,
  output logic [DATA_W-1:0] o_sram_dq_out,
  output logic              o_sram_dq_oe,
  input  logic [DATA_W-1:0] i_sram_dq_in,
  output logic              o_sram_we_n,
  output logic              o_sram_oe_n,
  output logic              o_sram_ce_n,
  output logic              o_sram_lb_n,
  output logic              o_sram_ub_n
);

  localparam int CNT_W = (ACCESS_CYC > 1) ? $clog2(ACCESS_CYC) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ACCESS_CYC - 1);
  localparam int STV_W = $clog2(STARVE_MAX + 1);
  localparam logic [STV_W-1:0] STV_MAX = STV_W'(STARVE_MAX);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    TURN   = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [STV_W-1:0]  starve_q, starve_d;
  logic              owner_g_q, owner_g_d;
  logic              wr_q, wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] dq_out_q, dq_out_d;
  logic              dq_oe_q, dq_oe_d;
  logic              we_n_q, we_n_d;
  logic              oe_n_q, oe_n_d;
  logic              ce_n_q, ce_n_d;
  logic              lb_n_q, lb_n_d;
  logic              ub_n_q, ub_n_d;
  logic              vid_gnt_q, vid_gnt_d;
  logic              gm_gnt_q, gm_gnt_d;
  logic              vid_rvalid_q, vid_rvalid_d;
  logic              gm_rvalid_q, gm_rvalid_d;
  logic [DATA_W-1:0] vid_rdata_q, vid_rdata_d;
  logic [DATA_W-1:0] gm_rdata_q, gm_rdata_d;
  logic              g_win, grant_v, grant_g;

  // Next-state, strobe and starvation-counter logic; every output is computed one cycle ahead
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    owner_g_d    = owner_g_q;
    wr_d         = wr_q;
    addr_d       = addr_q;
    dq_out_d     = dq_out_q;
    dq_oe_d      = dq_oe_q;
    we_n_d       = we_n_q;
    oe_n_d       = oe_n_q;
    ce_n_d       = ce_n_q;
    lb_n_d       = lb_n_q;
    ub_n_d       = ub_n_q;
    vid_gnt_d    = 1'b0;
    gm_gnt_d     = 1'b0;
    vid_rvalid_d = 1'b0;
    gm_rvalid_d  = 1'b0;
    vid_rdata_d  = vid_rdata_q;
    gm_rdata_d   = gm_rdata_q;
    grant_v      = 1'b0;
    grant_g      = 1'b0;
    g_win        = i_gm_req && (!i_vid_req || (starve_q == STV_MAX));

    case (state_q)
      IDLE: begin
        if (i_vid_req || i_gm_req) begin
          grant_g   = g_win;
          grant_v   = !g_win;
          owner_g_d = g_win;
          state_d   = ACCESS;
          cnt_d     = '0;
          ce_n_d    = 1'b0;
          if (g_win) begin
            gm_gnt_d = 1'b1;
            addr_d   = i_gm_addr;
            wr_d     = i_gm_we;
            dq_out_d = i_gm_wdata;
          end else begin
            vid_gnt_d = 1'b1;
            addr_d    = i_vid_addr;
            wr_d      = 1'b0;
          end
          if (g_win && i_gm_we) begin
            we_n_d  = 1'b0;
            oe_n_d  = 1'b1;
            dq_oe_d = 1'b1;
            lb_n_d  = ~i_gm_be[0];
            ub_n_d  = ~i_gm_be[1];
          end else begin
            we_n_d  = 1'b1;
            oe_n_d  = 1'b0;
            dq_oe_d = 1'b0;
            lb_n_d  = 1'b0;
            ub_n_d  = 1'b0;
          end
        end else begin
          ce_n_d  = 1'b1;
          oe_n_d  = 1'b1;
          we_n_d  = 1'b1;
          dq_oe_d = 1'b0;
          lb_n_d  = 1'b1;
          ub_n_d  = 1'b1;
        end
      end
      ACCESS: begin
        if (cnt_q == LAST_CNT) begin
          if (wr_q) begin
            // Turnaround: release WE but keep driving data/address for hold time
            state_d = TURN;
            we_n_d  = 1'b1;
          end else begin
            state_d = IDLE;
            ce_n_d  = 1'b1;
            oe_n_d  = 1'b1;
            we_n_d  = 1'b1;
            dq_oe_d = 1'b0;
            lb_n_d  = 1'b1;
            ub_n_d  = 1'b1;
            if (owner_g_q) begin
              gm_rdata_d  = i_sram_dq_in;
              gm_rvalid_d = 1'b1;
            end else begin
              vid_rdata_d  = i_sram_dq_in;
              vid_rvalid_d = 1'b1;
            end
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      TURN: begin
        state_d = IDLE;
        ce_n_d  = 1'b1;
        oe_n_d  = 1'b1;
        we_n_d  = 1'b1;
        dq_oe_d = 1'b0;
        lb_n_d  = 1'b1;
        ub_n_d  = 1'b1;
      end
      default: begin
        state_d = IDLE;
        ce_n_d  = 1'b1;
        oe_n_d  = 1'b1;
        we_n_d  = 1'b1;
        dq_oe_d = 1'b0;
        lb_n_d  = 1'b1;
        ub_n_d  = 1'b1;
      end
    endcase

    // Counts V wins that G has had to wait through; saturates so the guard stays armed
    if (!i_gm_req) begin
      starve_d = '0;
    end else if (grant_g) begin
      starve_d = '0;
    end else if (grant_v && (starve_q != STV_MAX)) begin
      starve_d = starve_q + STV_W'(1);
    end else begin
      starve_d = starve_q;
    end
  end

  // State and output registers with synchronous reset
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      starve_q     <= '0;
      owner_g_q    <= 1'b0;
      wr_q         <= 1'b0;
      addr_q       <= '0;
      dq_out_q     <= '0;
      dq_oe_q      <= 1'b0;
      we_n_q       <= 1'b1;
      oe_n_q       <= 1'b1;
      ce_n_q       <= 1'b1;
      lb_n_q       <= 1'b1;
      ub_n_q       <= 1'b1;
      vid_gnt_q    <= 1'b0;
      gm_gnt_q     <= 1'b0;
      vid_rvalid_q <= 1'b0;
      gm_rvalid_q  <= 1'b0;
      vid_rdata_q  <= '0;
      gm_rdata_q   <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      starve_q     <= starve_d;
      owner_g_q    <= owner_g_d;
      wr_q         <= wr_d;
      addr_q       <= addr_d;
      dq_out_q     <= dq_out_d;
      dq_oe_q      <= dq_oe_d;
      we_n_q       <= we_n_d;
      oe_n_q       <= oe_n_d;
      ce_n_q       <= ce_n_d;
      lb_n_q       <= lb_n_d;
      ub_n_q       <= ub_n_d;
      vid_gnt_q    <= vid_gnt_d;
      gm_gnt_q     <= gm_gnt_d;
      vid_rvalid_q <= vid_rvalid_d;
      gm_rvalid_q  <= gm_rvalid_d;
      vid_rdata_q  <= vid_rdata_d;
      gm_rdata_q   <= gm_rdata_d;
    end
  end

  assign o_vid_gnt     = vid_gnt_q;
  assign o_vid_rdata   = vid_rdata_q;
  assign o_vid_rvalid  = vid_rvalid_q;
  assign o_gm_gnt      = gm_gnt_q;
  assign o_gm_rdata    = gm_rdata_q;
  assign o_gm_rvalid   = gm_rvalid_q;
  assign o_sram_addr   = addr_q;
  assign o_sram_dq_out = dq_out_q;
  assign o_sram_dq_oe  = dq_oe_q;
  assign o_sram_we_n   = we_n_q;
  assign o_sram_oe_n   = oe_n_q;
  assign o_sram_ce_n   = ce_n_q;
  assign o_sram_lb_n   = lb_n_q;
  assign o_sram_ub_n   = ub_n_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Scoreboard bench for sram_arbiter: directed requests push expected grants/read data,
// a negedge monitor pops and compares them and watches the DQ contention invariant.
module tb_sram_arbiter;
  localparam int AW = 20;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          vid_req, vid_gnt, vid_rvalid;
  logic [AW-1:0] vid_addr;
  logic [DW-1:0] vid_rdata;
  logic          gm_req, gm_we, gm_gnt, gm_rvalid;
  logic [AW-1:0] gm_addr;
  logic [DW-1:0] gm_wdata, gm_rdata;
  logic [1:0]    gm_be;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_dq_out, sram_dq_in;
  logic          sram_dq_oe, sram_we_n, sram_oe_n, sram_ce_n, sram_lb_n, sram_ub_n;

  sram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .ACCESS_CYC(2), .STARVE_MAX(8)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_vid_req(vid_req), .i_vid_addr(vid_addr), .o_vid_gnt(vid_gnt),
    .o_vid_rdata(vid_rdata), .o_vid_rvalid(vid_rvalid),
    .i_gm_req(gm_req), .i_gm_we(gm_we), .i_gm_addr(gm_addr), .i_gm_wdata(gm_wdata),
    .i_gm_be(gm_be), .o_gm_gnt(gm_gnt), .o_gm_rdata(gm_rdata), .o_gm_rvalid(gm_rvalid),
    .o_sram_addr(sram_addr), .o_sram_dq_out(sram_dq_out), .o_sram_dq_oe(sram_dq_oe),
    .i_sram_dq_in(sram_dq_in), .o_sram_we_n(sram_we_n), .o_sram_oe_n(sram_oe_n),
    .o_sram_ce_n(sram_ce_n), .o_sram_lb_n(sram_lb_n), .o_sram_ub_n(sram_ub_n)
  );

  initial forever #5 clk = ~clk;

  int vectors = 0;
  int errs = 0;
  int cyc = 0;
  int last_v_gnt = 0;
  int last_g_gnt = 0;
  int exp_gnt[$];
  logic [DW-1:0] exp_vid[$];
  logic [DW-1:0] exp_gm[$];
  logic [DW-1:0] mem [int];

  function automatic logic [DW-1:0] mem_rd(input int a);
    if (mem.exists(a)) return mem[a];
    return 16'h0000;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Waits (bounded) for the grant of port g (0=V, 1=G); n = cycles waited
  task automatic wait_gnt(input bit g, output int n);
    bit got;
    got = 1'b0;
    n = 0;
    while (!got && n < 40) begin
      @(posedge clk);
      #1;
      n++;
      got = g ? (gm_gnt === 1'b1) : (vid_gnt === 1'b1);
    end
    if (!got) begin
      vectors++;
      errs++;
      $display("FAIL gnt_timeout: port %0d got no grant in %0d cycles, expected one", g, n);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // SRAM model: byte-masked write while WE low, read data presented while OE low
  initial forever begin
    logic [DW-1:0] w;
    @(negedge clk);
    if (sram_ce_n === 1'b0 && sram_we_n === 1'b0) begin
      w = mem_rd(int'(sram_addr));
      if (sram_lb_n === 1'b0) w[7:0] = sram_dq_out[7:0];
      if (sram_ub_n === 1'b0) w[15:8] = sram_dq_out[15:8];
      mem[int'(sram_addr)] = w;
    end
    if (sram_ce_n === 1'b0 && sram_oe_n === 1'b0) sram_dq_in = mem_rd(int'(sram_addr));
    else sram_dq_in = 16'h0000;
  end

  // Monitor: pops expected grants and read data as the DUT presents them
  initial forever begin
    int port;
    @(negedge clk);
    if (sram_dq_oe === 1'b1 && sram_oe_n === 1'b0) begin
      errs++;
      $display("FAIL contention: dq_oe=1 while oe_n=0 at cycle %0d, required never", cyc);
    end
    if (vid_gnt === 1'b1 && gm_gnt === 1'b1) begin
      errs++;
      $display("FAIL dual_gnt: both grants high at cycle %0d, required at most one", cyc);
    end
    if (vid_gnt === 1'b1 || gm_gnt === 1'b1) begin
      port = (gm_gnt === 1'b1) ? 1 : 0;
      if (port == 1) last_g_gnt = cyc;
      else last_v_gnt = cyc;
      if (exp_gnt.size() == 0) begin
        errs++;
        $display("FAIL gnt_unexpected: port %0d granted at cycle %0d, required none", port, cyc);
      end else begin
        chk("gnt_port", port, exp_gnt.pop_front());
      end
    end
    if (vid_rvalid === 1'b1) begin
      if (exp_vid.size() == 0) begin
        errs++;
        $display("FAIL vid_rvalid_unexpected: data 0x%0h at cycle %0d, required none", vid_rdata, cyc);
      end else begin
        chk("vid_rdata", vid_rdata, exp_vid.pop_front());
        chk("vid_rvalid_lat", cyc - last_v_gnt, 2);
      end
    end
    if (gm_rvalid === 1'b1) begin
      if (exp_gm.size() == 0) begin
        errs++;
        $display("FAIL gm_rvalid_unexpected: data 0x%0h at cycle %0d, required none", gm_rdata, cyc);
      end else begin
        chk("gm_rdata", gm_rdata, exp_gm.pop_front());
        chk("gm_rvalid_lat", cyc - last_g_gnt, 2);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int prev;
    rst = 1'b1; vid_req = 1'b0; vid_addr = '0;
    gm_req = 1'b0; gm_we = 1'b0; gm_addr = '0; gm_wdata = '0; gm_be = 2'b00;
    sram_dq_in = 16'h0000;
    mem[32'h00123] = 16'hBEEF;
    mem[32'h0ABCD] = 16'h5678;
    mem[32'h00200] = 16'h2200;
    mem[32'h00201] = 16'h2201;
    for (int i = 0; i < 16; i++) begin
      mem[32'h00100 + i] = 16'h1000 + 16'(i);
      mem[32'h00400 + i] = 16'hC000 + 16'(i);
    end

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    chk("rst_gnt", {vid_gnt, gm_gnt}, 2'b00);
    chk("rst_rvalid", {vid_rvalid, gm_rvalid}, 2'b00);
    chk("rst_rdata", {vid_rdata, gm_rdata}, 32'h0);
    chk("rst_addr", sram_addr, 20'h0);
    chk("rst_strobes", {sram_dq_oe, sram_we_n, sram_oe_n, sram_ce_n, sram_lb_n, sram_ub_n}, 6'b011111);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Single V read
    exp_gnt.push_back(0);
    exp_vid.push_back(16'hBEEF);
    vid_addr = 20'h00123;
    vid_req = 1'b1;
    wait_gnt(1'b0, n);
    vid_req = 1'b0;
    chk("v_gnt_lat", n, 1);
    chk("v_rd_addr", sram_addr, 20'h00123);
    chk("v_rd_strobes", {sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe}, 4'b0010);
    repeat (4) @(posedge clk);
    #1;

    // G write (lower byte only) followed immediately by a G read of the same word
    exp_gnt.push_back(1);
    exp_gnt.push_back(1);
    exp_gm.push_back(16'h5634);
    gm_addr = 20'h0ABCD; gm_we = 1'b1; gm_wdata = 16'h1234; gm_be = 2'b01;
    gm_req = 1'b1;
    wait_gnt(1'b1, n);
    chk("g_wr_gnt_lat", n, 1);
    chk("g_wr_acc1", {sram_ce_n, sram_oe_n, sram_we_n, sram_dq_oe, sram_lb_n, sram_ub_n}, 6'b010101);
    chk("g_wr_addr", sram_addr, 20'h0ABCD);
    chk("g_wr_data", sram_dq_out, 16'h1234);
    gm_we = 1'b0;
    @(posedge clk);
    #1;
    chk("g_wr_acc2", {sram_ce_n, sram_we_n, sram_dq_oe}, 3'b001);
    @(posedge clk);
    #1;
    chk("g_wr_turn", {sram_we_n, sram_dq_oe}, 2'b11);
    chk("g_wr_turn_hold", {sram_addr, sram_dq_out}, {20'h0ABCD, 16'h1234});
    @(posedge clk);
    #1;
    chk("g_wr_idle", {sram_ce_n, sram_dq_oe}, 2'b10);
    chk("g_wr_mem", mem_rd(32'h0ABCD), 16'h5634);
    wait_gnt(1'b1, n);
    gm_req = 1'b0;
    chk("g_rd_after_wr_lat", n, 1);
    repeat (4) @(posedge clk);
    #1;

    // Continuous contention: 8 V grants then 1 G grant, twice
    for (int k = 0; k < 2; k++) begin
      for (int j = 0; j < 8; j++) exp_gnt.push_back(0);
      exp_gnt.push_back(1);
    end
    fork
      begin
        int nv;
        for (int i = 0; i < 16; i++) begin
          vid_addr = 20'h00100 + 20'(i);
          exp_vid.push_back(16'h1000 + 16'(i));
          vid_req = 1'b1;
          wait_gnt(1'b0, nv);
        end
        vid_req = 1'b0;
      end
      begin
        int ng;
        for (int i = 0; i < 2; i++) begin
          gm_addr = 20'h00200 + 20'(i);
          gm_we = 1'b0;
          exp_gm.push_back(16'h2200 + 16'(i));
          gm_req = 1'b1;
          wait_gnt(1'b1, ng);
        end
        gm_req = 1'b0;
      end
    join
    repeat (5) @(posedge clk);
    #1;

    // Reset in the second ACCESS cycle of a write
    exp_gnt.push_back(1);
    gm_addr = 20'h00300; gm_we = 1'b1; gm_wdata = 16'hAAAA; gm_be = 2'b11;
    gm_req = 1'b1;
    wait_gnt(1'b1, n);
    gm_req = 1'b0;
    gm_we = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_mid_pre", sram_we_n, 1'b0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_mid_strobes", {sram_we_n, sram_dq_oe, sram_ce_n, sram_oe_n}, 4'b1011);
    chk("rst_mid_gnt_rv", {vid_gnt, gm_gnt, vid_rvalid, gm_rvalid}, 4'b0000);
    chk("rst_mid_rdata", vid_rdata, 16'h0000);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    exp_gnt.push_back(0);
    exp_vid.push_back(16'hBEEF);
    vid_addr = 20'h00123;
    vid_req = 1'b1;
    wait_gnt(1'b0, n);
    vid_req = 1'b0;
    chk("post_rst_v_lat", n, 1);
    repeat (4) @(posedge clk);
    #1;

    // V-only back-to-back stream
    prev = 0;
    for (int i = 0; i < 16; i++) begin
      exp_gnt.push_back(0);
      exp_vid.push_back(16'hC000 + 16'(i));
      vid_addr = 20'h00400 + 20'(i);
      vid_req = 1'b1;
      wait_gnt(1'b0, n);
      if (i > 0) chk("v_stream_gap", cyc - prev, 3);
      prev = cyc;
    end
    vid_req = 1'b0;
    repeat (6) @(posedge clk);
    #1;

    chk("vid_queue_drained", exp_vid.size(), 0);
    chk("gm_queue_drained", exp_gm.size(), 0);
    chk("gnt_queue_drained", exp_gnt.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
- Shares the single off-chip 16-bit SRAM between two requesters:
  - the VGA frame fetch (port V, read-only, latency-critical);
  - the game engine (port G, read/write, sprite and frame-buffer updates).
- Sequences SRAM timing: address/OE/WE phases and write turnaround.
- Fixed video priority, with a bounded-starvation guard for port G.
- Sits between game/render logic and the top-level SRAM pins; the tristate for DQ is built at the top level from o_sram_dq_out/o_sram_dq_oe.

Parameters:
- ADDR_W, 20, SRAM word address width.
- DATA_W, 16, SRAM data width.
- ACCESS_CYC, 2, clock cycles an address/strobe is held per access (>=1; 2 at 108 MHz).
- STARVE_MAX, 8, maximum consecutive V grants while G is pending before G is forced.

Ports:
- i_clk  in  1  system clock (108 MHz domain)
- i_rst  in  1  synchronous reset, active-high
- i_vid_req  in  1  video read request; held until o_vid_gnt
- i_vid_addr  in  ADDR_W  video read address
- o_vid_gnt  out  1  one-cycle pulse: V access started
- o_vid_rdata  out  DATA_W  read data, valid with o_vid_rvalid, held until next rvalid
- o_vid_rvalid  out  1  one-cycle read-data strobe
- i_gm_req  in  1  game request; held until o_gm_gnt
- i_gm_we  in  1  1 = write, 0 = read
- i_gm_addr  in  ADDR_W  game address
- i_gm_wdata  in  DATA_W  write data
- i_gm_be  in  2  byte enables [1]=upper, [0]=lower (writes only)
- o_gm_gnt  out  1  one-cycle pulse: G access started
- o_gm_rdata  out  DATA_W  read data, held until next G rvalid
- o_gm_rvalid  out  1  one-cycle read-data strobe (reads only)
- o_sram_addr  out  ADDR_W  SRAM address
- o_sram_dq_out  out  DATA_W  write data to pad
- o_sram_dq_oe  out  1  1 = drive DQ
- i_sram_dq_in  in  DATA_W  data from pad
- o_sram_we_n, o_sram_oe_n, o_sram_ce_n, o_sram_lb_n, o_sram_ub_n  out  1 each  SRAM strobes, active-low

Behaviour:
- Reset values (synchronous, i_rst high at a rising edge):
  - state = IDLE; starvation counter = 0;
  - all gnt/rvalid = 0; rdata = 0;
  - o_sram_addr = 0; dq_oe = 0; we_n = oe_n = ce_n = lb_n = ub_n = 1.
- Reset mid-access: the access aborts and strobes deassert on the next edge. No rvalid is issued. Requesters re-issue after reset.
- States: IDLE, ACCESS, TURN. All outputs are registered.
- IDLE:
  - Evaluates requests at edge t.
  - If any request is present, the winner is latched (addr/we/wdata/be). State -> ACCESS.
  - The winner's gnt is high during cycle t+1, and SRAM drive starts at t+1.
- Arbitration:
  - V wins, unless G is pending and starve_cnt == STARVE_MAX; then G wins.
  - starve_cnt increments on each V grant while i_gm_req = 1.
  - starve_cnt clears on a G grant, or in any cycle i_gm_req = 0.
  - starve_cnt saturates at STARVE_MAX.
- ACCESS lasts exactly ACCESS_CYC cycles:
  - ce_n = 0 throughout.
  - Read: oe_n = 0, we_n = 1, lb_n = ub_n = 0, dq_oe = 0.
  - Write: oe_n = 1, we_n = 0, dq_oe = 1, lb_n = ~be[0], ub_n = ~be[1].
- Read completion:
  - i_sram_dq_in is sampled at the last ACCESS edge.
  - The owner's rdata updates and rvalid pulses in the next cycle (t+ACCESS_CYC+1).
  - State -> IDLE, strobes go inactive (oe_n = 1).
  - Read latency from request sample = ACCESS_CYC+1 cycles; read throughput = 1 per ACCESS_CYC+1 cycles.
- Write completion:
  - -> TURN for 1 cycle: we_n = 1, dq_oe = 1, data and address held (hold time).
  - Then -> IDLE with dq_oe = 0.
  - Write occupancy = ACCESS_CYC+2 cycles. No rvalid.
- Idle strobes: ce_n = 1, oe_n = 1, we_n = 1, dq_oe = 0. o_sram_addr holds its last value.
- Requester rule: req/addr/data stay stable until gnt. After the gnt cycle, req may stay high for a next access; it is re-arbitrated in the next IDLE.
- Only one gnt is ever high in a cycle; gnt and rvalid of different ports may coincide.
- i_vid_req with G idle never triggers the guard. A V-only stream of back-to-back reads gets a grant every ACCESS_CYC+1 cycles.
- dq_oe is never 1 while oe_n = 0 (bus-contention invariant; assert in the bench).

Test Plan:
- Reset, then a single V read at addr 0x00123 with the SRAM model returning 0xBEEF:
  - o_vid_gnt is high 1 cycle after the request;
  - o_vid_rvalid is high 3 cycles after the request with rdata 0xBEEF (ACCESS_CYC = 2);
  - no G strobes.
- G write addr 0x0ABCD, data 0x1234, be = 2'b01:
  - we_n low for exactly 2 cycles, lb_n = 0, ub_n = 1;
  - TURN cycle with we_n = 1 and dq_oe = 1;
  - the model holds 0x??34 in the lower byte only; no gm_rvalid.
- V and G requesting simultaneously, continuously (STARVE_MAX = 8): grant pattern is 8 V grants, then 1 G grant, repeating; starve_cnt returns to 0 after each G grant.
- G read immediately following a G write to the same address: returns the written data; dq_oe = 0 and oe_n = 0 never overlap with dq_oe = 1 (checked every cycle).
- i_rst asserted in the 2nd ACCESS cycle of a write:
  - next cycle we_n = 1, dq_oe = 0, state IDLE, no gnt or rvalid;
  - a subsequent V read completes normally.
- V-only back-to-back stream of 16 sequential addresses: 16 rvalids spaced 3 cycles apart, in order, with matching data.
